multiplication_algo: RTL and testbench
======================================

Name: multiplication_algo

Overview:
- Unsigned sequential multiplier that computes in_a × in_b by repeated addition: in_a is added to an accumulator in_b times.
- Operands are accepted with a valid/ready handshake. The result is returned with a one-cycle valid_out pulse.
- Small arithmetic helper block. It trades latency (in_b+1 cycles) for area: one adder and one down-counter, no array multiplier.

Parameters:
- WIDTH, 4, operand width in bits. The result is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- in_a  input  WIDTH  multiplicand, unsigned.
- in_b  input  WIDTH  multiplier (iteration count), unsigned.
- valid_in  input  1  operands valid this cycle.
- ready_out  output  1  block idle and able to accept operands.
- mult_out  output  2*WIDTH  product, unsigned; holds last result.
- valid_out  output  1  one-cycle pulse marking a new product on mult_out.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, accumulator=0, counter=0, mult_out=0, valid_out=0.
  - Reset has priority over all other activity; valid_in is ignored in that cycle.
  - ready_out reads 1 after reset.
- ready_out = (state==IDLE), decoded combinationally from registered state.
- Accept: a rising edge with state==IDLE and valid_in=1 and rst_n=1.
  - Registers a_reg<=in_a, counter<=in_b, acc<=0, state<=BUSY.
  - valid_in while not IDLE is ignored. Operands are not buffered; upstream must hold valid_in until ready_out is seen high.
- BUSY, each edge:
  - If counter!=0: acc<=acc+a_reg (2*WIDTH-bit add, zero-extended a_reg), counter<=counter-1.
  - If counter==0: mult_out<=acc, valid_out<=1, state<=IDLE.
- valid_out:
  - Registered, high for exactly one cycle, cleared at the next edge.
  - It may be high in the same cycle that ready_out is high, so a new accept can coincide with the valid_out cycle.
- Latency: accept at edge 0; valid_out rises at edge in_b+1.
  - Busy time is in_b+1 cycles; throughput is one result per in_b+2 cycles with back-to-back valid_in.
- mult_out:
  - Holds its value between results.
  - Changes only on the completion edge or on reset; never shows partial sums.
- Width: the 2*WIDTH accumulator cannot overflow, since max (2^WIDTH-1)^2 < 2^(2*WIDTH). No saturation logic is required.
- Boundaries:
  - in_b=0: BUSY for one cycle; mult_out=0, valid_out at edge 1.
  - in_a=0: in_b additions of zero; result 0.
  - in_a=in_b=max: full count, result 8'hE1 for WIDTH=4.
  - Reset mid-operation: computation aborted, no valid_out, outputs per reset values.
  - Changes on in_a/in_b after accept have no effect on the running computation.
- FSM: IDLE -> BUSY on accept; BUSY -> BUSY while counter!=0; BUSY -> IDLE when counter==0. Reset returns to IDLE from any state.

Decomposition:
- Package multiplication_algo_pkg: state enum (IDLE, BUSY) as a 1-bit typedef; default WIDTH constant.
- Single module. The adder, counter and FSM are small enough that no sub-module is warranted.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with valid_in=1 -> mult_out=0, valid_out=0, ready_out=1; no accept occurs.
- Basic multiply: a=5, b=2 presented one cycle while ready -> ready_out low for 3 cycles; valid_out pulses one cycle at edge 3 with mult_out=8'h0A; ready_out returns high.
- Busy drop then retry:
  - a=5, b=2 accepted.
  - Next cycle a=2, b=15, valid_in held ~4 cycles -> second operand ignored while busy, then accepted when ready_out=1.
  - Result 8'h1E after 16 busy cycles; mult_out holds 8'h0A in between.
- Zero cases: b=0 with a=9 -> valid_out at edge 1, mult_out=0; a=0, b=7 -> mult_out=0 after 8 cycles.
- Max operands: a=15, b=15 -> mult_out=8'hE1, exactly one valid_out pulse, no overflow.
- Reset mid-operation: a=3, b=12 accepted, rst_n low at cycle 5 -> no valid_out, mult_out=0, ready_out=1; a following a=4, b=4 -> mult_out=8'h10.

Source files
------------

// File: rtl/multiplication_algo_pkg.sv
// -----------------------------------------------------------------------------
// multiplication_algo_pkg
// Shared definitions for the repeated-addition multiplier:
//   - DEFAULT_WIDTH : default operand width in bits (result is 2*WIDTH bits)
//   - state_t       : controller state encoding (IDLE, BUSY)
// -----------------------------------------------------------------------------
package multiplication_algo_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage : multiplication_algo_pkg

// File: rtl/multiplication_algo.sv
// -----------------------------------------------------------------------------
// multiplication_algo
// Unsigned sequential multiplier: mult_out = in_a * in_b, computed by adding
// in_a into an accumulator in_b times. One adder and one down-counter.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_a       in   [WIDTH-1:0]   multiplicand
//   in_b       in   [WIDTH-1:0]   multiplier / iteration count
//   valid_in   in   operands valid this cycle
//   ready_out  out  block idle, operands accepted on the next edge if valid_in
//   mult_out   out  [2*WIDTH-1:0] product, holds the last result
//   valid_out  out  one-cycle pulse marking a new product on mult_out
//
// Handshake: operands transfer on a rising edge where valid_in and ready_out
// are both high. There is no operand buffer; valid_in while busy is dropped,
// so the source must keep valid_in and its operands stable until it sees
// ready_out high. valid_out is a single-cycle strobe with no back-pressure.
//
// Timing: accept at edge 0, valid_out rises at edge in_b+1. valid_out and
// ready_out are high together in the completion cycle, so a new accept can
// land on the edge that clears valid_out.
// -----------------------------------------------------------------------------
module multiplication_algo
  import multiplication_algo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [2*WIDTH-1:0] mult_out,
  output logic               valid_out
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mult;
  logic                 r_valid;

  logic                 w_accept;
  logic                 w_cnt_zero;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_acc_sum;

  assign w_accept   = (r_state == IDLE) && valid_in;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_a_ext    = {{WIDTH{1'b0}}, r_a};
  // (2^W-1)^2 < 2^(2W): the accumulator cannot wrap, no carry-out needed.
  assign w_acc_sum  = r_acc + w_a_ext;

  // ---------------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_nxt = BUSY;
      BUSY:    if (w_cnt_zero) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, accumulate/count, result publish
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mult  <= '0;
      r_valid <= 1'b0;
    end else begin
      // valid_out is a strobe: cleared on every edge unless re-asserted below.
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= in_a;
            r_cnt <= in_b;
            r_acc <= '0;
          end
        end
        BUSY: begin
          if (!w_cnt_zero) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt - WIDTH'(1);
          end else begin
            // Only the final sum reaches mult_out; partial sums stay internal.
            r_mult  <= r_acc;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_out = (r_state == IDLE);
  assign mult_out  = r_mult;
  assign valid_out = r_valid;

endmodule : multiplication_algo

// File: tb/tb_multiplication_algo.sv
// -----------------------------------------------------------------------------
// tb_multiplication_algo
// Directed bench for the repeated-addition multiplier. Inputs are driven 1 ns
// after a rising edge and outputs are sampled at the same point, so every
// sample reflects the state right after the edge just taken.
// -----------------------------------------------------------------------------
module tb_multiplication_algo;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           valid_in;
  logic           ready_out;
  logic [2*W-1:0] mult_out;
  logic           valid_out;

  int checks;
  int errors;

  multiplication_algo #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .mult_out  (mult_out),
    .valid_out (valid_out)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge (edge 0 of the transaction), then scramble
  // the operand inputs to show they no longer matter.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    in_a     = a;
    in_b     = b;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    in_a     = W'($urandom_range(0, 15));
    in_b     = W'($urandom_range(0, 15));
  endtask

  // Step edges until valid_out is seen; n = edges taken (0 on timeout).
  // changes counts samples where mult_out moved away from 'hold' early.
  task automatic wait_done(input logic [2*W-1:0] hold, output int n, output int changes);
    n       = 0;
    changes = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (valid_out) begin
        n = i;
        break;
      end
      if (mult_out !== hold) changes++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    valid_in = 1'b1;
    in_a     = 4'd5;
    in_b     = 4'd3;
    tick();
    tick();
    checks++;
    if (mult_out !== 8'h00) begin errors++; $display("FAIL reset_mult actual=%h required=00", mult_out); end
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid actual=%b required=0", valid_out); end
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready actual=%b required=1", ready_out); end
    valid_in = 1'b0;
    rst_n    = 1'b1;
    tick();
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_no_accept ready actual=%b required=1", ready_out); end
  endtask

  task automatic test_basic();
    int busy;
    start(4'd5, 4'd2);
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      if (ready_out === 1'b0) busy++;
      if (i < 2) tick();
    end
    checks++;
    if (busy != 3) begin errors++; $display("FAIL basic_busy_cycles actual=%0d required=3", busy); end
    tick();
    checks++;
    if (valid_out !== 1'b1 || mult_out !== 8'h0A) begin
      errors++; $display("FAIL basic_result valid=%b mult=%h required valid=1 mult=0a", valid_out, mult_out);
    end
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("FAIL basic_ready_back actual=%b required=1", ready_out); end
    tick();
    checks++;
    if (valid_out !== 1'b0 || mult_out !== 8'h0A) begin
      errors++; $display("FAIL basic_pulse_hold valid=%b mult=%h required valid=0 mult=0a", valid_out, mult_out);
    end
  endtask

  task automatic test_busy_retry();
    int n;
    int ch;
    start(4'd5, 4'd2);          // edge 0: accept 5*2
    in_a     = 4'd2;
    in_b     = 4'd15;
    valid_in = 1'b1;            // held while busy
    tick();                     // edge 1
    tick();                     // edge 2
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL retry_ignored ready actual=%b required=0", ready_out); end
    tick();                     // edge 3: first result
    checks++;
    if (valid_out !== 1'b1 || mult_out !== 8'h0A) begin
      errors++; $display("FAIL retry_first valid=%b mult=%h required valid=1 mult=0a", valid_out, mult_out);
    end
    tick();                     // edge 4: second operand accepted
    valid_in = 1'b0;
    in_a     = 4'd7;
    in_b     = 4'd1;
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL retry_accept ready actual=%b required=0", ready_out); end
    wait_done(8'h0A, n, ch);
    checks++;
    if (n != 16) begin errors++; $display("FAIL retry_latency actual=%0d required=16", n); end
    checks++;
    if (ch != 0) begin errors++; $display("FAIL retry_hold changes actual=%0d required=0", ch); end
    checks++;
    if (mult_out !== 8'h1E) begin errors++; $display("FAIL retry_result actual=%h required=1e", mult_out); end
  endtask

  task automatic test_zero();
    int n;
    int ch;
    start(4'd9, 4'd0);
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL zero_b_busy ready actual=%b required=0", ready_out); end
    wait_done(8'h1E, n, ch);
    checks++;
    if (n != 1 || mult_out !== 8'h00) begin
      errors++; $display("FAIL zero_b latency=%0d mult=%h required latency=1 mult=00", n, mult_out);
    end
    tick();
    start(4'd0, 4'd7);
    wait_done(8'h00, n, ch);
    checks++;
    if (n != 8 || mult_out !== 8'h00 || ch != 0) begin
      errors++; $display("FAIL zero_a latency=%0d mult=%h changes=%0d required latency=8 mult=00 changes=0", n, mult_out, ch);
    end
  endtask

  task automatic test_max();
    int n;
    int ch;
    int extra;
    tick();
    start(4'd15, 4'd15);
    wait_done(8'h00, n, ch);
    checks++;
    if (n != 16 || mult_out !== 8'hE1) begin
      errors++; $display("FAIL max latency=%0d mult=%h required latency=16 mult=e1", n, mult_out);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (valid_out !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0 || mult_out !== 8'hE1) begin
      errors++; $display("FAIL max_single_pulse extra=%0d mult=%h required extra=0 mult=e1", extra, mult_out);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int ch;
    int stray;
    start(4'd3, 4'd12);         // edge 0
    for (int i = 0; i < 4; i++) tick();   // edges 1..4
    rst_n = 1'b0;
    tick();                     // edge 5: reset
    rst_n = 1'b1;
    checks++;
    if (mult_out !== 8'h00 || valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_mid mult=%h valid=%b ready=%b required mult=00 valid=0 ready=1", mult_out, valid_out, ready_out);
    end
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid_out !== 1'b0 || ready_out !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL reset_mid_abort stray=%0d required=0", stray); end
    start(4'd4, 4'd4);
    wait_done(8'h00, n, ch);
    checks++;
    if (n != 5 || mult_out !== 8'h10) begin
      errors++; $display("FAIL reset_mid_next latency=%0d mult=%h required latency=5 mult=10", n, mult_out);
    end
  endtask

  // New accept on the edge that ends the valid_out cycle.
  task automatic test_back_to_back();
    int n;
    int ch;
    tick();
    start(4'd3, 4'd1);          // edge 0
    in_a     = 4'd6;
    in_b     = 4'd2;
    valid_in = 1'b1;
    tick();                     // edge 1
    tick();                     // edge 2: first result
    checks++;
    if (valid_out !== 1'b1 || ready_out !== 1'b1 || mult_out !== 8'h03) begin
      errors++; $display("FAIL b2b_first valid=%b ready=%b mult=%h required valid=1 ready=1 mult=03", valid_out, ready_out, mult_out);
    end
    tick();                     // edge 3: accept during valid_out cycle
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || ready_out !== 1'b0) begin
      errors++; $display("FAIL b2b_accept valid=%b ready=%b required valid=0 ready=0", valid_out, ready_out);
    end
    wait_done(8'h03, n, ch);
    checks++;
    if (n != 3 || mult_out !== 8'h0C || ch != 0) begin
      errors++; $display("FAIL b2b_second latency=%0d mult=%h changes=%0d required latency=3 mult=0c changes=0", n, mult_out, ch);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    in_a     = '0;
    in_b     = '0;
    #1;
    test_reset();
    test_basic();
    test_busy_retry();
    test_zero();
    test_max();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multiplication_algo
